// File: rtl/a2d_sched_pkg.sv
// a2d_sched_pkg: shared types, widths and helpers for the ADC128S conversion scheduler.
package a2d_sched_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned CMD_W  = 16;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned NUM_RR = 3;

    localparam logic [CH_W-1:0] LFT_CH  = 3'd0;
    localparam logic [CH_W-1:0] RGHT_CH = 3'd4;
    localparam logic [CH_W-1:0] BATT_CH = 3'd5;

    localparam logic [PTR_W-1:0] PTR_LFT  = 2'd0;
    localparam logic [PTR_W-1:0] PTR_RGHT = 2'd1;
    localparam logic [PTR_W-1:0] PTR_BATT = 2'd2;

    typedef enum logic [1:0] {IDLE, CNV1, GAP, CNV2} state_e;
    typedef enum logic {SRC_RR, SRC_OD} src_e;

    // SPI command word selecting an A2D channel
    function automatic logic [CMD_W-1:0] mk_cmd(input logic [CH_W-1:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

    function automatic logic [CH_W-1:0] rr_ch(input logic [PTR_W-1:0] ptr);
        case (ptr)
            PTR_RGHT: rr_ch = RGHT_CH;
            PTR_BATT: rr_ch = BATT_CH;
            default:  rr_ch = LFT_CH;
        endcase
    endfunction

endpackage

// File: rtl/a2d_ch_filt.sv
// a2d_ch_filt: rounding average of previous and new 12-bit sample; first sample after reset loads directly.
// Only compiled when A2D_SCHED_FILT_EN is defined.
`ifdef A2D_SCHED_FILT_EN
module a2d_ch_filt
    import a2d_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_i,
    input  logic [DATA_W-1:0] smp_i,
    output logic [DATA_W-1:0] res_o
);

    logic [DATA_W-1:0] res_q, res_d;
    logic              vld_q, vld_d;
    logic [DATA_W:0]   sum_c;

    always_comb begin
        res_d = res_q;
        vld_d = vld_q;
        sum_c = (DATA_W+1)'(res_q) + (DATA_W+1)'(smp_i) + (DATA_W+1)'(1);
        if (ld_i) begin
            res_d = vld_q ? sum_c[DATA_W:1] : smp_i;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end

    assign res_o = res_q;

endmodule
`endif

// File: rtl/a2d_sched.sv
// a2d_sched: round-robin (left, right, battery) and on-demand conversion scheduler for the ADC128S SPI master.
// Define A2D_SCHED_FILT_EN to average successive round-robin samples per channel.
module a2d_sched
    import a2d_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nxt,
    input  logic              req,
    input  logic [CH_W-1:0]   req_ch,
    output logic              req_ack,
    output logic [DATA_W-1:0] req_data,
    output logic [DATA_W-1:0] lft_ld,
    output logic [DATA_W-1:0] rght_ld,
    output logic [DATA_W-1:0] batt,
    output logic              rr_done,
    output logic              busy,
    output logic              wrt,
    output logic [CMD_W-1:0]  wt_data,
    input  logic              done,
    input  logic [CMD_W-1:0]  rd_data
);

    state_e             state_q, state_d;
    src_e               src_q, src_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               nxt_pend_q, nxt_pend_d;
    logic               wrt_q, wrt_d;
    logic [CMD_W-1:0]   wt_data_q, wt_data_d;
    logic               busy_q, busy_d;
    logic               req_ack_q, req_ack_d;
    logic               rr_done_q, rr_done_d;
    logic [DATA_W-1:0]  req_data_q, req_data_d;
    logic [NUM_RR-1:0]  rr_ld_c;
    logic [DATA_W-1:0]  smp_c;
    logic               unused_hi;

`ifndef A2D_SCHED_FILT_EN
    logic [DATA_W-1:0]  lft_q, lft_d, rght_q, rght_d, batt_q, batt_d;
`endif

    assign smp_c     = rd_data[DATA_W-1:0];
    assign unused_hi = ^rd_data[CMD_W-1:DATA_W];

    // Next-state, grant arbitration and result capture
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        ptr_d      = ptr_q;
        nxt_pend_d = nxt_pend_q | nxt;
        wrt_d      = 1'b0;
        wt_data_d  = wt_data_q;
        req_ack_d  = 1'b0;
        rr_done_d  = 1'b0;
        req_data_d = req_data_q;
        rr_ld_c    = '0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    src_d     = SRC_OD;
                    wt_data_d = mk_cmd(req_ch);
                    wrt_d     = 1'b1;
                    state_d   = CNV1;
                end else if (nxt_pend_q || nxt) begin
                    src_d      = SRC_RR;
                    wt_data_d  = mk_cmd(rr_ch(ptr_q));
                    wrt_d      = 1'b1;
                    state_d    = CNV1;
                    // a fresh nxt only re-arms if one was already pending
                    nxt_pend_d = nxt_pend_q & nxt;
                end
            end
            CNV1: begin
                if (done) state_d = GAP;
            end
            GAP: begin
                wrt_d   = 1'b1;
                state_d = CNV2;
            end
            CNV2: begin
                if (done) begin
                    state_d = IDLE;
                    if (src_q == SRC_OD) begin
                        req_data_d = smp_c;
                        req_ack_d  = 1'b1;
                    end else begin
                        rr_ld_c   = NUM_RR'(1) << ptr_q;
                        rr_done_d = 1'b1;
                        ptr_d     = (ptr_q == PTR_BATT) ? PTR_LFT : ptr_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

`ifndef A2D_SCHED_FILT_EN
        lft_d  = lft_q;
        rght_d = rght_q;
        batt_d = batt_q;
        if (rr_ld_c[0]) lft_d  = smp_c;
        if (rr_ld_c[1]) rght_d = smp_c;
        if (rr_ld_c[2]) batt_d = smp_c;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= SRC_RR;
            ptr_q      <= PTR_LFT;
            nxt_pend_q <= 1'b0;
            wrt_q      <= 1'b0;
            wt_data_q  <= '0;
            busy_q     <= 1'b0;
            req_ack_q  <= 1'b0;
            rr_done_q  <= 1'b0;
            req_data_q <= '0;
`ifndef A2D_SCHED_FILT_EN
            lft_q      <= '0;
            rght_q     <= '0;
            batt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            ptr_q      <= ptr_d;
            nxt_pend_q <= nxt_pend_d;
            wrt_q      <= wrt_d;
            wt_data_q  <= wt_data_d;
            busy_q     <= busy_d;
            req_ack_q  <= req_ack_d;
            rr_done_q  <= rr_done_d;
            req_data_q <= req_data_d;
`ifndef A2D_SCHED_FILT_EN
            lft_q      <= lft_d;
            rght_q     <= rght_d;
            batt_q     <= batt_d;
`endif
        end
    end

`ifdef A2D_SCHED_FILT_EN
    a2d_ch_filt u_filt_lft  (.clk(clk), .rst_n(rst_n), .ld_i(rr_ld_c[0]), .smp_i(smp_c), .res_o(lft_ld));
    a2d_ch_filt u_filt_rght (.clk(clk), .rst_n(rst_n), .ld_i(rr_ld_c[1]), .smp_i(smp_c), .res_o(rght_ld));
    a2d_ch_filt u_filt_batt (.clk(clk), .rst_n(rst_n), .ld_i(rr_ld_c[2]), .smp_i(smp_c), .res_o(batt));
`else
    assign lft_ld  = lft_q;
    assign rght_ld = rght_q;
    assign batt    = batt_q;
`endif

    assign wrt      = wrt_q;
    assign wt_data  = wt_data_q;
    assign busy     = busy_q;
    assign req_ack  = req_ack_q;
    assign rr_done  = rr_done_q;
    assign req_data = req_data_q;

endmodule
